apb_master_gen2: RTL

APB_MASTER_GEN2 -- requirements
Module: apb_master_gen2

---
 rtl/apb_master_gen2.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/apb_master_gen2.sv
// APB master with a fixed slot address map, per-slot select,
// wait-state handling, access timeout and registered completion.
module apb_master_gen2 #(
  parameter int          NUM_SLAVES = 15,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] MAP_BASE   = 32'h1000_0000,
  parameter int          SLOT_LOG2  = 10,
  parameter int          TIMEOUT    = 255
) (
  input  logic                         PCLK,
  input  logic                         PRESETn,
  output logic [31:0]                  PADDR,
  output logic [DATA_W-1:0]            PWDATA,
  output logic                         PWRITE,
  output logic                         PENABLE,
  output logic [DATA_W/8-1:0]          PSTRB,
  output logic [NUM_SLAVES-1:0]        PSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
  input  logic [NUM_SLAVES-1:0]        PREADY,
  input  logic [NUM_SLAVES-1:0]        PSLVERR,
  input  logic                         transfer,
  input  logic [31:0]                  addr,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         write,
  output logic                         ready,
  output logic [DATA_W-1:0]            rdata,
  output logic                         err,
  output logic                         busy
);

  localparam int SW = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t state, state_nx;

  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [SW-1:0]     req_wstrb;
  logic              req_write;
  logic [15:0]       cnt;

  logic [31:0]       idx;
  logic              hit;
  logic              sel_ready;
  logic              sel_err;
  logic [DATA_W-1:0] sel_rdata;
  logic              tout;
  logic              done;
  logic              accept;

  assign idx = (req_addr - MAP_BASE) >> SLOT_LOG2;
  assign hit = (req_addr >= MAP_BASE) &&
               (idx < 32'(NUM_SLAVES));

  always_comb begin
    sel_ready = 1'b0;
    sel_err   = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (hit && idx == 32'(i)) begin
        sel_ready = PREADY[i];
        sel_err   = PSLVERR[i];
        sel_rdata = PRDATA[i*DATA_W +: DATA_W];
      end
    end
  end

  // Timeout only fires when the selected slave is still stalling.
  assign tout = hit && !sel_ready &&
                (cnt == 16'(TIMEOUT - 1));
  assign done = (state == ACCESS) &&
                (!hit || sel_ready || tout);

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      IDLE: begin
        if (transfer) begin
          state_nx = SETUP;
          accept   = 1'b1;
        end
      end
      SETUP: state_nx = ACCESS;
      ACCESS: begin
        if (done) begin
          if (transfer && !tout) begin
            state_nx = SETUP;
            accept   = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      req_addr  <= '0;
      req_wdata <= '0;
      req_wstrb <= '0;
      req_write <= 1'b0;
    end else if (accept) begin
      req_addr  <= addr;
      req_wdata <= wdata;
      req_wstrb <= wstrb;
      req_write <= write;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cnt <= '0;
    end else if (state == SETUP) begin
      cnt <= '0;
    end else if (state == ACCESS) begin
      cnt <= cnt + 16'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      ready <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      ready <= done;
      if (done) begin
        err   <= !hit || tout || sel_err;
        rdata <= (hit && !tout && !sel_err && !req_write)
               ? sel_rdata : '0;
      end
    end
  end

  always_comb begin
    PSEL = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      PSEL[i] = (state != IDLE) && hit && (idx == 32'(i));
    end
  end

  assign busy    = (state != IDLE);
  assign PENABLE = (state == ACCESS);
  assign PWRITE  = busy && req_write;
  assign PSTRB   = (busy && req_write) ? req_wstrb : '0;
  assign PADDR   = req_addr;
  assign PWDATA  = req_wdata;

endmodule
